// File: rtl/fetch_prefetch_if.sv
// Decode-side and instruction-RAM read-channel signals of the fetch front end.
// master: the fetch unit; slave: the decode stage and RAM environment.
interface fetch_prefetch_if #(
  parameter int AWIDTH = 32,
  parameter int LWIDTH = 4,
  parameter int DWIDTH = 32
);
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              ir_valid;
  logic [31:0]       ir;
  logic [31:0]       ir_pc;
  logic              ir_ready;
  logic [AWIDTH-1:0] ram_araddr;
  logic [LWIDTH-1:0] ram_arlen;
  logic              ram_arvalid;
  logic              ram_arready;
  logic [DWIDTH-1:0] ram_rdata;
  logic              ram_rvalid;
  logic              ram_rready;
  logic              ram_rlast;

  modport master (
    input  redirect_valid, redirect_pc, ir_ready,
    input  ram_arready, ram_rdata, ram_rvalid, ram_rlast,
    output ir_valid, ir, ir_pc,
    output ram_araddr, ram_arlen, ram_arvalid, ram_rready
  );

  modport slave (
    output redirect_valid, redirect_pc, ir_ready,
    output ram_arready, ram_rdata, ram_rvalid, ram_rlast,
    input  ir_valid, ir, ir_pc,
    input  ram_araddr, ram_arlen, ram_arvalid, ram_rready
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Burst instruction prefetcher: credit-gated RAM bursts into a DEPTH-entry FIFO, redirect flush/drain.
// Define FETCH_PREFETCH_BYPASS_EN to forward a beat straight to decode when the FIFO is empty.
module fetch_prefetch #(
  parameter int          DEPTH     = 8,
  parameter int          BURST_LEN = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_prefetch_if.master bus
);
  localparam int            PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW          = $clog2(DEPTH) + 2;
  localparam logic [CW-1:0] FILL_LIMIT  = CW'(DEPTH - BURST_LEN);
  localparam logic [CW-1:0] BURST_CNT   = CW'(BURST_LEN);
  localparam logic [31:0]   BURST_BYTES = 32'(4 * BURST_LEN);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [31:0]   beat_pc_q, beat_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          redir_pend_q, redir_pend_d;
  logic          arvalid_q, rready_q;
  logic [31:0]   mem_ir_q [DEPTH];
  logic [31:0]   mem_pc_q [DEPTH];
  logic          beat, fifo_valid, push, pop, bypass_hit;
  logic [31:0]   redir_pc;

  assign redir_pc   = bus.redirect_pc & 32'hFFFF_FFFC;
  assign beat       = bus.ram_rvalid & rready_q;
  assign fifo_valid = (count_q != '0);

  assign bus.ram_araddr  = araddr_q;
  assign bus.ram_arlen   = bus.LWIDTH'(BURST_LEN - 1);
  assign bus.ram_arvalid = arvalid_q;
  assign bus.ram_rready  = rready_q;

`ifdef FETCH_PREFETCH_BYPASS_EN
  assign bypass_hit   = !fifo_valid && (state_q == DATA) && bus.ram_rvalid;
  assign bus.ir_valid = fifo_valid | bypass_hit;
  assign bus.ir       = fifo_valid ? mem_ir_q[rd_ptr_q] : (bypass_hit ? bus.ram_rdata : 32'h0);
  assign bus.ir_pc    = fifo_valid ? mem_pc_q[rd_ptr_q] : (bypass_hit ? beat_pc_q : 32'h0);
`else
  assign bypass_hit   = 1'b0;
  assign bus.ir_valid = fifo_valid;
  assign bus.ir       = fifo_valid ? mem_ir_q[rd_ptr_q] : 32'h0;
  assign bus.ir_pc    = fifo_valid ? mem_pc_q[rd_ptr_q] : 32'h0;
`endif

  // A beat consumed directly by decode through the bypass is never stored.
  assign push = beat && (state_q == DATA) && !bus.redirect_valid && !(bypass_hit && bus.ir_ready);
  assign pop  = fifo_valid && bus.ir_ready && !bus.redirect_valid;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    araddr_d     = araddr_q;
    beat_pc_d    = beat_pc_q;
    inflight_d   = inflight_q;
    redir_pend_d = redir_pend_q;
    case (state_q)
      IDLE: begin
        // A redirect empties the FIFO, so the credit check is trivially met.
        if (bus.redirect_valid) begin
          fetch_pc_d = redir_pc;
          araddr_d   = redir_pc;
          state_d    = ADDR;
        end else if ((count_q + inflight_q) <= FILL_LIMIT) begin
          araddr_d = fetch_pc_q;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (bus.redirect_valid) begin
          fetch_pc_d   = redir_pc;
          redir_pend_d = 1'b1;
        end
        if (bus.ram_arready) begin
          inflight_d   = BURST_CNT;
          beat_pc_d    = araddr_q;
          redir_pend_d = 1'b0;
          if (bus.redirect_valid || redir_pend_q) begin
            state_d = DRAIN;
          end else begin
            fetch_pc_d = fetch_pc_q + BURST_BYTES;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (beat) begin
          inflight_d = inflight_q - 1'b1;
          beat_pc_d  = beat_pc_q + 32'd4;
          if (bus.ram_rlast) state_d = IDLE;
        end
        if (bus.redirect_valid) begin
          fetch_pc_d = redir_pc;
          state_d    = (beat && bus.ram_rlast) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (beat) begin
          inflight_d = inflight_q - 1'b1;
          if (bus.ram_rlast) state_d = IDLE;
        end
        if (bus.redirect_valid) fetch_pc_d = redir_pc;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      araddr_q     <= RESET_PC;
      count_q      <= '0;
      inflight_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      redir_pend_q <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      araddr_q     <= araddr_d;
      count_q      <= count_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      redir_pend_q <= redir_pend_d;
      arvalid_q    <= (state_d == ADDR);
      rready_q     <= (state_d == DATA) || (state_d == DRAIN);
    end
  end

  always_ff @(posedge clk) begin
    beat_pc_q <= beat_pc_d;
    if (push) begin
      mem_ir_q[wr_ptr_q] <= bus.ram_rdata;
      mem_pc_q[wr_ptr_q] <= beat_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a burst RAM model (latency 2, rdata = ~address).
// Bypass expectations follow FETCH_PREFETCH_BYPASS_EN when the bench is built with it.
module tb_fetch_prefetch;
  localparam int          DEPTH = 8;
  localparam int          BL    = 4;
  localparam int          LAT   = 2;
  localparam logic [31:0] RPC   = 32'h100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ar_block = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  fetch_prefetch_if ifc ();

  fetch_prefetch #(.DEPTH(DEPTH), .BURST_LEN(BL), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  always #5 clk = ~clk;

  // RAM model
  logic        m_rvalid = 1'b0;
  logic        m_rlast  = 1'b0;
  logic [31:0] m_rdata  = 32'h0;
  logic [31:0] m_addr   = 32'h0;
  int          m_idx    = 0;
  int          cyc      = 0;
  int          total_beats = 0;
  logic [31:0] arq_addr[$];
  int          arq_due[$];
  logic [31:0] ar_log[$];

  assign ifc.ram_arready = !ar_block;
  assign ifc.ram_rvalid  = m_rvalid;
  assign ifc.ram_rlast   = m_rlast;
  assign ifc.ram_rdata   = m_rdata;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      arq_addr.delete();
      arq_due.delete();
      ar_log.delete();
      m_rvalid    <= 1'b0;
      m_rlast     <= 1'b0;
      m_idx       <= 0;
      total_beats <= 0;
    end else begin
      if (ifc.ram_arvalid && ifc.ram_arready) begin
        arq_addr.push_back(ifc.ram_araddr);
        arq_due.push_back(cyc + LAT);
        ar_log.push_back(ifc.ram_araddr);
      end
      if (m_rvalid && ifc.ram_rready) begin
        total_beats <= total_beats + 1;
        if (m_rlast) begin
          m_rvalid <= 1'b0;
          m_rlast  <= 1'b0;
        end else begin
          m_rdata <= ~(m_addr + 32'(4 * (m_idx + 1)));
          m_rlast <= (m_idx + 1 == BL - 1);
          m_idx   <= m_idx + 1;
        end
      end else if (!m_rvalid && arq_addr.size() > 0 && cyc >= arq_due[0]) begin
        m_addr   <= arq_addr[0];
        m_rdata  <= ~arq_addr[0];
        m_rlast  <= (BL == 1);
        m_idx    <= 0;
        m_rvalid <= 1'b1;
        void'(arq_addr.pop_front());
        void'(arq_due.pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Monitor: decode consumption and burst length at rlast
  logic [31:0] got_pc[$];
  logic [31:0] got_ir[$];
  int          bc = 0;

  always @(negedge clk) begin
    if (rst) begin
      bc <= 0;
    end else begin
      if (ifc.ir_valid && ifc.ir_ready && !ifc.redirect_valid) begin
        got_pc.push_back(ifc.ir_pc);
        got_ir.push_back(ifc.ir);
      end
      if (ifc.ram_rvalid && ifc.ram_rready) begin
        if (ifc.ram_rlast) begin
          chk("rlast_beat_count", 32'(bc + 1), 32'(BL));
          bc <= 0;
        end else begin
          bc <= bc + 1;
        end
      end
    end
  end

  task automatic do_reset(input logic rdy, input logic blk);
    @(negedge clk);
    rst = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'h0;
    ifc.ir_ready = rdy;
    ar_block = blk;
    repeat (2) @(negedge clk);
    got_pc.delete();
    got_ir.delete();
    rst = 1'b0;
  endtask

  task automatic wait_got(input string tag, input int n);
    int k;
    for (k = 0; k < 300 && got_pc.size() < n; k++) @(negedge clk);
    chk(tag, 32'(got_pc.size() >= n), 32'd1);
  endtask

  task automatic wait_ar(input string tag, input int n);
    int k;
    for (k = 0; k < 300 && ar_log.size() < n; k++) @(negedge clk);
    chk(tag, 32'(ar_log.size() >= n), 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pc"}, got_pc[i], base + 32'(4 * i));
      chk({tag, "_ir"}, got_ir[i], ~(base + 32'(4 * i)));
    end
  endtask

  initial begin
    int k;
    int snap;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 32'h0;
    ifc.ir_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ir_valid", 32'(ifc.ir_valid), 32'd0);
    chk("rst_ir", ifc.ir, 32'h0);
    chk("rst_ir_pc", ifc.ir_pc, 32'h0);
    chk("rst_arvalid", 32'(ifc.ram_arvalid), 32'd0);
    chk("rst_araddr", ifc.ram_araddr, RPC);
    chk("rst_rready", 32'(ifc.ram_rready), 32'd0);
    rst = 1'b0;

    // Streaming fetch from RESET_PC
    wait_ar("t2_ar_wait", 1);
    chk("t2_araddr", ar_log[0], 32'h100);
    chk("t2_arlen", 32'(ifc.ram_arlen), 32'd3);
    wait_got("t2_got_wait", 12);
    check_seq("t2", 32'h100, 12);

    // Decode stalled: credit stops requests at a full FIFO
    do_reset(1'b0, 1'b0);
    repeat (60) @(negedge clk);
    chk("t3_bursts", 32'(ar_log.size()), 32'(DEPTH / BL));
    chk("t3_arvalid", 32'(ifc.ram_arvalid), 32'd0);
    chk("t3_count", 32'(dut.count_q), 32'd8);
    ifc.ir_ready = 1'b1;
    wait_got("t3_got_wait", 12);
    check_seq("t3", 32'h100, 12);

    // Redirect on beat 2 of a burst
    do_reset(1'b0, 1'b0);
    for (k = 0; k < 300 && !(m_rvalid && ifc.ram_rready && m_idx == 1); k++) @(negedge clk);
    chk("t4_beat2_wait", 32'(m_rvalid && ifc.ram_rready && m_idx == 1), 32'd1);
    chk("t4_pre_ir_valid", 32'(ifc.ir_valid), 32'd1);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h2003;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    chk("t4_post_ir_valid", 32'(ifc.ir_valid), 32'd0);
    snap = total_beats;
    ifc.ir_ready = 1'b1;
    wait_ar("t4_ar_wait", 2);
    chk("t4_drained", 32'(total_beats - snap), 32'd2);
    chk("t4_araddr", ar_log[1], 32'h2000);
    wait_got("t4_got_wait", 4);
    check_seq("t4", 32'h2000, 4);

    // Redirect while the address phase is stalled
    do_reset(1'b1, 1'b1);
    for (k = 0; k < 50 && !ifc.ram_arvalid; k++) @(negedge clk);
    chk("t5_arvalid_wait", 32'(ifc.ram_arvalid), 32'd1);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h3000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      ifc.redirect_valid = 1'b0;
      chk("t5_hold_araddr", ifc.ram_araddr, 32'h100);
      chk("t5_hold_arvalid", 32'(ifc.ram_arvalid), 32'd1);
    end
    chk("t5_no_handshake", 32'(ar_log.size()), 32'd0);
    ar_block = 1'b0;
    wait_ar("t5_ar_wait", 2);
    chk("t5_araddr0", ar_log[0], 32'h100);
    chk("t5_araddr1", ar_log[1], 32'h3000);
    chk("t5_drained", 32'(total_beats), 32'd4);
    chk("t5_nothing_out", 32'(got_pc.size()), 32'd0);
    wait_got("t5_got_wait", 4);
    check_seq("t5", 32'h3000, 4);

    // Redirect together with a pop on a full FIFO
    do_reset(1'b0, 1'b0);
    repeat (60) @(negedge clk);
    chk("t6_full", 32'(dut.count_q), 32'd8);
    ifc.ir_ready = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h4000;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    chk("t6_ir_valid", 32'(ifc.ir_valid), 32'd0);
    chk("t6_count", 32'(dut.count_q), 32'd0);
    chk("t6_arvalid", 32'(ifc.ram_arvalid), 32'd1);
    chk("t6_araddr", ifc.ram_araddr, 32'h4000);
    chk("t6_no_void_pop", 32'(got_pc.size()), 32'd0);
    wait_got("t6_got_wait", 4);
    check_seq("t6", 32'h4000, 4);

    // First-beat latency to decode with an empty FIFO
    do_reset(1'b1, 1'b0);
    for (k = 0; k < 50 && !(ifc.ram_rvalid && ifc.ram_rready); k++) @(negedge clk);
    chk("t7_beat_wait", 32'(ifc.ram_rvalid && ifc.ram_rready), 32'd1);
`ifdef FETCH_PREFETCH_BYPASS_EN
    chk("t7_bypass_valid", 32'(ifc.ir_valid), 32'd1);
    chk("t7_bypass_pc", ifc.ir_pc, 32'h100);
    chk("t7_bypass_ir", ifc.ir, ~32'h100);
`else
    chk("t7_same_cycle_valid", 32'(ifc.ir_valid), 32'd0);
    @(negedge clk);
    chk("t7_next_valid", 32'(ifc.ir_valid), 32'd1);
    chk("t7_next_pc", ifc.ir_pc, 32'h100);
    chk("t7_next_ir", ifc.ir, ~32'h100);
`endif
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
